// File: rtl/pusch_crc_pkg.sv
// Shared constants, state encoding and counter sizing for the PUSCH CRC attachment stage.
package pusch_crc_pkg;

    localparam int unsigned CRC_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WAIT_CRC,
        SEND_DATA,
        SEND_CRC
    } crc_attach_state_e;

    // One extra bit so that the value MAX_BITS itself is representable.
    function automatic int unsigned cnt_width(input int unsigned max_bits);
        return $clog2(max_bits) + 1;
    endfunction

    function automatic int unsigned addr_width(input int unsigned max_bits);
        return (max_bits > 1) ? $clog2(max_bits) : 1;
    endfunction

endpackage

// File: rtl/tb_bit_buffer.sv
// 1-bit-wide simple dual-port payload RAM: synchronous write, registered read.
module tb_bit_buffer #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_bit,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_bit
);

    logic mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_bit;
        end
        if (rd_en) begin
            rd_bit <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/crc_attach.sv
// Transport-block CRC attachment: buffers the payload bit stream, latches the parity
// word from the CRC generator, then emits payload + CRC as one valid/ready serial frame.
module crc_attach #(
    parameter int unsigned MAX_BITS = 1024,
    parameter int unsigned CRC_W    = pusch_crc_pkg::CRC_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DATA,
    input  logic             ACTIVE,
    input  logic [CRC_W-1:0] CRC_IN,
    input  logic             CRC_VALID,
    input  logic             OUT_READY,
    output logic             OUT_BIT,
    output logic             OUT_VALID,
    output logic             OUT_LAST,
    output logic             BUSY,
    output logic             OVERFLOW
);

    import pusch_crc_pkg::*;

    localparam int unsigned CW = cnt_width(MAX_BITS);
    localparam int unsigned AW = addr_width(MAX_BITS);
    localparam int unsigned IW = $clog2(CRC_W);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(CRC_W - 1);

    crc_attach_state_e state, state_nxt;

    logic [CW-1:0]    wr_cnt;
    logic [CW-1:0]    rd_cnt;
    logic [CW-1:0]    rd_nxt;
    logic [CRC_W-1:0] crc_lat;
    logic [IW-1:0]    idx;
    logic             ovf_q;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          ram_bit;
    logic          wr_first;
    logic          wr_inc;
    logic          ovf_set;
    logic          ovf_clr;
    logic          crc_load;
    logic          rd_inc;
    logic          idx_clr;
    logic          idx_inc;

    assign rd_nxt = rd_cnt + CW'(1);

    tb_bit_buffer #(
        .DEPTH (MAX_BITS),
        .AW    (AW)
    ) u_buf (
        .CLK     (CLK),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_bit  (DATA),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_bit  (ram_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_first  = 1'b0;
        wr_inc    = 1'b0;
        ovf_set   = 1'b0;
        ovf_clr   = 1'b0;
        crc_load  = 1'b0;
        rd_inc    = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        OUT_VALID = 1'b0;
        OUT_LAST  = 1'b0;
        OUT_BIT   = 1'b0;

        case (state)
            IDLE: begin
                if (ACTIVE) begin
                    wr_en     = 1'b1;
                    wr_first  = 1'b1;
                    ovf_clr   = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (ACTIVE) begin
                    if (wr_cnt < MAX_CNT) begin
                        wr_en   = 1'b1;
                        wr_addr = wr_cnt[AW-1:0];
                        wr_inc  = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else begin
                    state_nxt = WAIT_CRC;
                end
            end
            WAIT_CRC: begin
                // Prefetch bit 0 so it is on the RAM output when OUT_VALID rises.
                if (CRC_VALID) begin
                    crc_load  = 1'b1;
                    rd_en     = 1'b1;
                    state_nxt = SEND_DATA;
                end
            end
            SEND_DATA: begin
                OUT_VALID = 1'b1;
                OUT_BIT   = ram_bit;
                if (OUT_READY) begin
                    if (rd_cnt == wr_cnt - CW'(1)) begin
                        idx_clr   = 1'b1;
                        state_nxt = SEND_CRC;
                    end else begin
                        rd_inc  = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = rd_nxt[AW-1:0];
                    end
                end
            end
            SEND_CRC: begin
                OUT_VALID = 1'b1;
                OUT_BIT   = crc_lat[idx];
                OUT_LAST  = (idx == IDX_LAST);
                if (OUT_READY) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            crc_lat <= '0;
            idx     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_first) begin
                wr_cnt <= CW'(1);
            end else if (wr_inc) begin
                wr_cnt <= wr_cnt + CW'(1);
            end

            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end

            if (crc_load) begin
                crc_lat <= CRC_IN;
                rd_cnt  <= '0;
            end else if (rd_inc) begin
                rd_cnt <= rd_nxt;
            end

            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign BUSY     = (state != IDLE);
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_crc_attach.sv
// Self-checking bench for crc_attach: queue-based frame model, per-cycle output monitor.
module tb_crc_attach;

    localparam int unsigned MAXB = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        DATA = 1'b0;
    logic        ACTIVE = 1'b0;
    logic [15:0] CRC_IN = '0;
    logic        CRC_VALID = 1'b0;
    logic        OUT_READY = 1'b1;
    logic        OUT_BIT;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic        BUSY;
    logic        OVERFLOW;

    crc_attach #(
        .MAX_BITS (MAXB),
        .CRC_W    (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DATA      (DATA),
        .ACTIVE    (ACTIVE),
        .CRC_IN    (CRC_IN),
        .CRC_VALID (CRC_VALID),
        .OUT_READY (OUT_READY),
        .OUT_BIT   (OUT_BIT),
        .OUT_VALID (OUT_VALID),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int   tests = 0;
    int   fails = 0;
    bit   exp_q[$];
    bit   rx[$];
    logic exp_ovf = 1'b0;
    int   rdy_mode = 0;
    int   ready_phase = 0;
    bit   prev_stall = 1'b0;
    bit   prev_bit = 1'b0;
    bit   prev_last = 1'b0;

    logic [23:0] lit1 = 24'b1010_0101_0010_1100_0100_1000;
    logic [19:0] lit2 = 20'b1101_1000_0000_0000_0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Ready pattern: 0 = always high, 1 = repeating 1,0,0,1, 2 = random.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0: OUT_READY = 1'b1;
                1: begin
                    OUT_READY = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                    ready_phase++;
                end
                default: OUT_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_frame(input int len, input logic [31:0] bits,
                              input logic [15:0] crc, input int gap);
        for (int i = 0; i < len; i++) begin
            if (i < int'(MAXB)) exp_q.push_back(bits[i]);
        end
        for (int j = 0; j < 16; j++) exp_q.push_back(crc[j]);
        exp_ovf = (len > int'(MAXB));
        for (int i = 0; i < len; i++) begin
            ACTIVE = 1'b1;
            DATA   = bits[i];
            tick();
            if (i == 0) begin
                chk("ovf_clear_on_capture", OVERFLOW, 0);
                chk("busy_rise", BUSY, 1);
            end
        end
        ACTIVE = 1'b0;
        DATA   = 1'b0;
        tick();
        repeat (gap - 1) tick();
        CRC_IN    = crc;
        CRC_VALID = 1'b1;
        tick();
        CRC_VALID = 1'b0;
        CRC_IN    = 16'($urandom);
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            tick();
            done = (exp_q.size() == 0) && !OUT_VALID;
        end
        chk("frame_complete", done, 1);
        if (!done) exp_q.delete();
        chk("idle_busy", BUSY, 0);
        chk("idle_last", OUT_LAST, 0);
        chk("overflow_flag", OVERFLOW, exp_ovf);
    endtask

    task automatic check_seq(input string name, input int n, input logic [23:0] lit);
        chk({name, "_count"}, rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++) begin
            chk(name, rx[i], lit[n-1-i]);
        end
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge CLK);
                    if (!RST) begin
                        prev_stall = 1'b0;
                        prev_last  = 1'b0;
                    end else begin
                        if (prev_last) begin
                            chk("post_last_valid", OUT_VALID, 0);
                            chk("post_last_busy", BUSY, 0);
                        end
                        if (prev_stall) begin
                            chk("stall_valid", OUT_VALID, 1);
                            chk("stall_bit", OUT_BIT, prev_bit);
                        end
                        if (exp_q.size() == 0) begin
                            chk("spurious_valid", OUT_VALID, 0);
                        end else if (OUT_VALID) begin
                            chk("busy_during_send", BUSY, 1);
                            if (OUT_READY) begin
                                chk("out_bit", OUT_BIT, exp_q[0]);
                                chk("out_last", OUT_LAST, exp_q.size() == 1);
                                rx.push_back(OUT_BIT);
                                void'(exp_q.pop_front());
                            end
                        end
                        prev_stall = OUT_VALID && !OUT_READY;
                        prev_bit   = OUT_BIT;
                        prev_last  = OUT_VALID && OUT_READY && OUT_LAST;
                    end
                end
            end
            begin : stimulus
                logic [31:0] b;
                int          len;
                bit          ok;

                repeat (3) tick();
                chk("rst_valid", OUT_VALID, 0);
                chk("rst_bit", OUT_BIT, 0);
                chk("rst_last", OUT_LAST, 0);
                chk("rst_busy", BUSY, 0);
                chk("rst_overflow", OVERFLOW, 0);
                RST = 1'b1;
                tick();

                // Reference frame, ready held high.
                rdy_mode = 0;
                rx.delete();
                send_frame(8, 32'hA5, 16'h1234, 17);
                wait_done();
                check_seq("t1_seq", 24, lit1);

                // Same frame with ready toggling 1,0,0,1.
                rdy_mode    = 1;
                ready_phase = 0;
                rx.delete();
                send_frame(8, 32'hA5, 16'h1234, 17);
                wait_done();
                check_seq("t2_seq", 24, lit1);

                // Overflow: 20 bits into a 16-bit buffer.
                rdy_mode = 0;
                rx.delete();
                send_frame(20, $urandom, 16'hBEEF, 17);
                wait_done();
                chk("t3_count", rx.size(), 32);

                // ACTIVE during SEND_DATA and CRC_VALID during SEND_CRC are ignored.
                rx.delete();
                send_frame(8, $urandom, 16'($urandom), 17);
                ok = 1'b0;
                for (int k = 0; k < 100 && !ok; k++) begin
                    ok = OUT_VALID;
                    if (!ok) tick();
                end
                chk("t4_reach_send", ok, 1);
                for (int k = 0; k < 3; k++) begin
                    ACTIVE = 1'b1;
                    DATA   = 1'($urandom);
                    tick();
                end
                ACTIVE = 1'b0;
                for (int k = 0; k < 100 && rx.size() < 9; k++) tick();
                chk("t4_reach_crc", rx.size() >= 9, 1);
                CRC_IN    = 16'($urandom);
                CRC_VALID = 1'b1;
                tick();
                CRC_VALID = 1'b0;
                wait_done();
                chk("t4_count", rx.size(), 24);
                repeat (20) tick();
                chk("t4_no_new_frame", BUSY, 0);

                // CRC_VALID with no payload.
                CRC_IN    = 16'($urandom);
                CRC_VALID = 1'b1;
                tick();
                CRC_VALID = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    tick();
                    chk("t5_valid", OUT_VALID, 0);
                    chk("t5_busy", BUSY, 0);
                end

                // Reset at the 5th output transfer of an overflowed frame.
                rdy_mode = 0;
                rx.delete();
                send_frame(20, $urandom, 16'($urandom), 5);
                for (int k = 0; k < 100 && rx.size() < 4; k++) tick();
                chk("t6_reach_xfer5", rx.size(), 4);
                chk("t6_overflow_before", OVERFLOW, 1);
                #2;
                RST = 1'b0;
                exp_q.delete();
                exp_ovf = 1'b0;
                #1;
                chk("t6_rst_valid", OUT_VALID, 0);
                chk("t6_rst_last", OUT_LAST, 0);
                chk("t6_rst_busy", BUSY, 0);
                chk("t6_rst_overflow", OVERFLOW, 0);
                tick();
                tick();
                RST = 1'b1;
                tick();
                rx.delete();
                send_frame(4, 32'hB, 16'h8001, 17);
                wait_done();
                check_seq("t6_seq", 20, {4'b0, lit2});

                // Random frames with random ready behaviour.
                for (int f = 0; f < 10; f++) begin
                    rdy_mode = int'($urandom_range(0, 2));
                    len      = int'($urandom_range(1, 20));
                    b        = $urandom;
                    rx.delete();
                    send_frame(len, b, 16'($urandom), int'($urandom_range(1, 20)));
                    wait_done();
                    chk("rand_count", rx.size(), (len > int'(MAXB)) ? 32 : len + 16);
                end

                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        join
    end

endmodule
